// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS datapath: next-PC select codes,
// primary opcodes seen by the main decoder, and the default reset PC.
package mips_pkg;

    // Next-PC select (driven by the main control FSM)
    localparam logic [1:0] PCSRC_PLUS4   = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH  = 2'b01;
    localparam logic [1:0] PCSRC_JUMP    = 2'b10;
    localparam logic [1:0] PCSRC_ILLEGAL = 2'b11;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    // Default PC after reset (word aligned)
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/mc_fetch_regs_flopenr.sv
// flopenr: enable register with asynchronous active-low reset to RESET_VAL.
// Tie en high for a plain pipeline register.
module flopenr #(
    parameter int              WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load d when enabled; clear to RESET_VAL while reset is low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q <= RESET_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/mc_fetch_regs.sv
// mc_fetch_regs: PC/IR/MDR/A/B/ALUOut register stage of the multicycle MIPS
// datapath. Generates the memory address and the next PC from the control
// FSM's IorD/IRwrite/pcwrite/branch/pcsrc outputs.
// Optional feature macro: FETCH_COUNT_EN (saturating fetch counter on
// instr_count; when undefined instr_count is tied to 0).
module mc_fetch_regs
    import mips_pkg::*;
#(
    parameter int                WIDTH    = 32,
    parameter logic [WIDTH-1:0]  RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IorD,
    input  logic             IRwrite,
    input  logic             pcwrite,
    input  logic             branch,
    input  logic [1:0]       pcsrc,
    input  logic             zero,
    input  logic [WIDTH-1:0] aluresult,
    input  logic [WIDTH-1:0] memrdata,
    input  logic [WIDTH-1:0] rd1,
    input  logic [WIDTH-1:0] rd2,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] memaddr,
    output logic [WIDTH-1:0] instr,
    output logic [5:0]       op,
    output logic [5:0]       funct,
    output logic [WIDTH-1:0] mdr,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] aluout,
    output logic             pcen,
    output logic             pcsrc_err,
    output logic [31:0]      instr_count
);

    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] pc_d;
    logic             pcsrc_illegal;
    logic             pc_load;

    assign pcen          = pcwrite | (branch & zero);
    assign pcsrc_illegal = (pcsrc == PCSRC_ILLEGAL);
    // An illegal select must never corrupt the PC, so it gates the load
    assign pc_load       = pcen & ~pcsrc_illegal;

    // Next-PC selection; jump uses the IR value present this cycle
    always_comb begin
        pc_next = pc;
        case (pcsrc)
            PCSRC_PLUS4:  pc_next = aluresult;
            PCSRC_BRANCH: pc_next = aluout;
            PCSRC_JUMP:   pc_next = {pc[WIDTH-1:28], instr[25:0], 2'b00};
            default:      pc_next = pc;
        endcase
    end

    // PC is always word aligned regardless of the selected source
    assign pc_d = {pc_next[WIDTH-1:2], 2'b00};

    flopenr #(.WIDTH(WIDTH), .RESET_VAL(RESET_PC)) u_pc (
        .clk(clk), .reset(reset), .en(pc_load), .d(pc_d), .q(pc)
    );

    flopenr #(.WIDTH(WIDTH), .RESET_VAL('0)) u_ir (
        .clk(clk), .reset(reset), .en(IRwrite), .d(memrdata), .q(instr)
    );

    // Non-architectural registers that capture every cycle
    flopenr #(.WIDTH(WIDTH), .RESET_VAL('0)) u_mdr (
        .clk(clk), .reset(reset), .en(1'b1), .d(memrdata), .q(mdr)
    );

    flopenr #(.WIDTH(WIDTH), .RESET_VAL('0)) u_a (
        .clk(clk), .reset(reset), .en(1'b1), .d(rd1), .q(a)
    );

    flopenr #(.WIDTH(WIDTH), .RESET_VAL('0)) u_b (
        .clk(clk), .reset(reset), .en(1'b1), .d(rd2), .q(b)
    );

    flopenr #(.WIDTH(WIDTH), .RESET_VAL('0)) u_aluout (
        .clk(clk), .reset(reset), .en(1'b1), .d(aluresult), .q(aluout)
    );

    // Old PC drives the address during fetch even while the PC is loading
    assign memaddr = IorD ? aluout : pc;

    assign op    = instr[31:26];
    assign funct = instr[5:0];

    // Sticky flag: set when the controller tries to load PC with pcsrc=11
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pcsrc_err <= 1'b0;
        else if (pcen && pcsrc_illegal)
            pcsrc_err <= 1'b1;
    end

`ifdef FETCH_COUNT_EN
    logic [31:0] count_reg;

    // Count fetches (IR loads), saturating at all ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count_reg <= 32'd0;
        else if (IRwrite && (count_reg != 32'hFFFF_FFFF))
            count_reg <= count_reg + 32'd1;
    end

    assign instr_count = count_reg;
`else
    assign instr_count = 32'd0;
`endif

endmodule
